// File: rtl/led_mode_scheduler.sv
// led_mode_scheduler
// Arbitrates LED mode requests from NUM_REQ requesters (index 0 highest
// priority). A granted mode is held for at least HOLD_CYCLES cycles, during
// which only strictly higher-priority requesters can take over. While the held
// mode is "toggle" (11), a one-cycle csr_write strobe is produced every
// TOGGLE_PERIOD cycles. All outputs are registered.
//
// Ports
//   clock_sink_clk    in   1            clock, rising edge
//   reset_sink_reset  in   1            synchronous active-high reset
//   req_valid         in   NUM_REQ      per-requester request
//   req_mode          in   2*NUM_REQ    per-requester mode code, [2i+1:2i]
//   req_ready         out  NUM_REQ      one-cycle one-hot grant acknowledge
//   blink_flag        out  2            mode to the LED blink block
//   csr_write         out  1            one-cycle toggle strobe
//   grant_id          out  clog2(NUM_REQ) current owner, 0 when idle
//   busy              out  1            high while a mode is held
module led_mode_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned TOGGLE_PERIOD = 25000000
) (
    input  logic                       clock_sink_clk,
    input  logic                       reset_sink_reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [2*NUM_REQ-1:0]       req_mode,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [1:0]                 blink_flag,
    output logic                       csr_write,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned ID_W     = $clog2(NUM_REQ);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] TOG_LAST  = 32'(TOGGLE_PERIOD - 1);
    localparam logic [1:0]  MODE_TOGGLE = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic [1:0]          blink_q, blink_d;
    logic                csr_q, csr_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic                busy_q, busy_d;
    logic [31:0]         hold_cnt_q, hold_cnt_d;
    logic [31:0]         tog_cnt_q, tog_cnt_d;

    // Fixed-priority arbitration: lowest valid index wins.
    logic            any_valid;
    logic [ID_W-1:0] win_idx;
    logic [1:0]      win_mode;

    always_comb begin
        any_valid = |req_valid;
        win_idx   = '0;
        win_mode  = 2'b00;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_idx  = ID_W'(i);
                win_mode = req_mode[2*i +: 2];
            end
        end
    end

    logic expired;
    logic preempt;
    logic do_grant;

    // Since win_idx is the lowest valid index, a winner below the owner means
    // some strictly higher-priority requester is asking.
    assign expired = (hold_cnt_q == HOLD_LAST);
    assign preempt = any_valid && (win_idx < gid_q);

    always_comb begin
        state_d    = state_q;
        ready_d    = '0;
        blink_d    = blink_q;
        csr_d      = 1'b0;
        gid_d      = gid_q;
        busy_d     = busy_q;
        hold_cnt_d = hold_cnt_q;
        tog_cnt_d  = tog_cnt_q;
        do_grant   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    do_grant = 1'b1;
                end else begin
                    blink_d    = 2'b00;
                    gid_d      = '0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                    tog_cnt_d  = '0;
                end
            end
            S_HOLD: begin
                // Preemption and expiry share one arbitration, so at most one
                // req_ready pulse results even when both happen together.
                if (preempt || (expired && any_valid)) begin
                    do_grant = 1'b1;
                end else if (expired) begin
                    state_d    = S_IDLE;
                    blink_d    = 2'b00;
                    gid_d      = '0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                    tog_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                    if (blink_q == MODE_TOGGLE) begin
                        if (tog_cnt_q == TOG_LAST) begin
                            csr_d     = 1'b1;
                            tog_cnt_d = '0;
                        end else begin
                            tog_cnt_d = tog_cnt_q + 32'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A grant never strobes csr_write; the toggle period restarts here.
        if (do_grant) begin
            state_d    = S_HOLD;
            ready_d    = NUM_REQ'(1) << win_idx;
            blink_d    = win_mode;
            gid_d      = win_idx;
            busy_d     = 1'b1;
            hold_cnt_d = '0;
            tog_cnt_d  = '0;
            csr_d      = 1'b0;
        end
    end

    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            state_q    <= S_IDLE;
            ready_q    <= '0;
            blink_q    <= 2'b00;
            csr_q      <= 1'b0;
            gid_q      <= '0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            tog_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            blink_q    <= blink_d;
            csr_q      <= csr_d;
            gid_q      <= gid_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
            tog_cnt_q  <= tog_cnt_d;
        end
    end

    assign req_ready  = ready_q;
    assign blink_flag = blink_q;
    assign csr_write  = csr_q;
    assign grant_id   = gid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Testbench for led_mode_scheduler with NUM_REQ=4, HOLD_CYCLES=8,
// TOGGLE_PERIOD=3. A cycle-level reference model tracks the owner, its mode
// and the number of edges since the grant; outputs are compared every cycle.
// Directed scenarios add literal expectations at key points.
module tb_led_mode_scheduler;

    localparam int NR = 4;
    localparam int HC = 8;
    localparam int TP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [7:0] req_mode  = '0;
    logic [3:0] req_ready;
    logic [1:0] blink_flag;
    logic       csr_write;
    logic [1:0] grant_id;
    logic       busy;

    led_mode_scheduler #(
        .NUM_REQ      (NR),
        .HOLD_CYCLES  (HC),
        .TOGGLE_PERIOD(TP)
    ) dut (
        .clock_sink_clk  (clk),
        .reset_sink_reset(rst),
        .req_valid       (req_valid),
        .req_mode        (req_mode),
        .req_ready       (req_ready),
        .blink_flag      (blink_flag),
        .csr_write       (csr_write),
        .grant_id        (grant_id),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 when idle), latched mode, edges since grant.
    int         m_owner = -1;
    int         m_mode  = 0;
    int         m_age   = 0;
    logic [3:0] e_ready = '0;
    logic       e_csr   = 1'b0;
    bit         m_ok    = 1'b0;
    int         low;

    always @(posedge clk) begin
        low = -1;
        for (int i = NR - 1; i >= 0; i--) begin
            if (req_valid[i]) low = i;
        end
        e_ready = '0;
        e_csr   = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_mode  = 0;
            m_age   = 0;
            m_ok    = 1'b1;
        end else if (m_owner < 0) begin
            if (low >= 0) begin
                m_owner = low;
                m_mode  = int'(req_mode[2*low +: 2]);
                m_age   = 0;
                e_ready = 4'(1 << low);
            end
        end else begin
            m_age++;
            if (low >= 0 && (low < m_owner || m_age == HC)) begin
                m_owner = low;
                m_mode  = int'(req_mode[2*low +: 2]);
                m_age   = 0;
                e_ready = 4'(1 << low);
            end else if (m_age == HC) begin
                m_owner = -1;
            end else if (m_mode == 3 && (m_age % TP) == 0) begin
                e_csr = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_ready", 32'(req_ready), 32'(e_ready));
            chk("model_blink", 32'(blink_flag), (m_owner >= 0) ? m_mode : 0);
            chk("model_gid",   32'(grant_id),   (m_owner >= 0) ? m_owner : 0);
            chk("model_busy",  32'(busy),       (m_owner >= 0) ? 1 : 0);
            chk("model_csr",   32'(csr_write),  32'(e_csr));
        end
    end

    logic [10:0] csr_hist;
    logic [3:0]  tbl_valid [8] = '{4'b0000, 4'b1000, 4'b0100, 4'b0000,
                                   4'b0010, 4'b1001, 4'b0000, 4'b0001};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_blink", 32'(blink_flag), 32'h0);
        chk("rst_gid",   32'(grant_id),   32'h0);
        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_csr",   32'(csr_write),  32'h0);

        // Basic grant of requester 2, mode 01, on the first edge out of reset.
        req_mode  = 8'b00_01_00_00;
        rst       = 1'b0;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("g2_ready", 32'(req_ready), 32'h4);
        chk("g2_blink", 32'(blink_flag), 32'h1);
        chk("g2_gid",   32'(grant_id),   32'h2);
        chk("g2_busy",  32'(busy),       32'h1);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("g2_ready_pulse", 32'(req_ready), 32'h0);
        repeat (6) @(negedge clk);
        chk("g2_busy_e7", 32'(busy), 32'h1);
        @(negedge clk);
        chk("g2_busy_e8",  32'(busy),       32'h0);
        chk("g2_blink_e8", 32'(blink_flag), 32'h0);

        // Preemption of owner 2 by requester 0 at cycle 3.
        req_mode  = 8'b00_01_00_10;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("pre_gid",   32'(grant_id),   32'h0);
        chk("pre_blink", 32'(blink_flag), 32'h2);
        chk("pre_ready", 32'(req_ready),  32'h1);
        req_valid = 4'b0000;
        repeat (7) @(negedge clk);
        chk("pre_busy_hold", 32'(busy), 32'h1);
        @(negedge clk);
        chk("pre_busy_end", 32'(busy), 32'h0);

        // Lower-priority requester waits until the owner's hold expires.
        req_mode  = 8'b01_00_10_00;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("low_gid1", 32'(grant_id), 32'h1);
        req_valid = 4'b1000;
        for (int k = 1; k < HC; k++) begin
            @(negedge clk);
            chk("low_wait_ready", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        chk("low_exp_ready", 32'(req_ready),  32'h8);
        chk("low_exp_gid",   32'(grant_id),   32'h3);
        chk("low_exp_blink", 32'(blink_flag), 32'h1);
        req_valid = 4'b0000;
        repeat (9) @(negedge clk);

        // Toggle mode: strobes at cycles 3 and 6 after the grant edge only.
        req_mode  = 8'b00_00_00_11;
        req_valid = 4'b0001;
        csr_hist  = '0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            csr_hist[k] = csr_write;
            if (k == 0) req_valid = 4'b0000;
        end
        chk("tog_hist", 32'(csr_hist), 32'h048);

        // Reset landing on a strobe cycle wins over the strobe.
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_csr",   32'(csr_write),  32'h0);
        chk("rstmid_busy",  32'(busy),       32'h0);
        chk("rstmid_blink", 32'(blink_flag), 32'h0);
        chk("rstmid_gid",   32'(grant_id),   32'h0);
        chk("rstmid_ready", 32'(req_ready),  32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Requests 1 and 2 arriving exactly at owner 2's expiry edge.
        req_mode  = 8'b00_01_10_00;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (7) @(negedge clk);
        req_valid = 4'b0110;
        @(negedge clk);
        chk("exp_ready", 32'(req_ready),  32'h2);
        chk("exp_gid",   32'(grant_id),   32'h1);
        chk("exp_blink", 32'(blink_flag), 32'h2);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("exp_ready_pulse", 32'(req_ready), 32'h0);
        repeat (9) @(negedge clk);

        // Mode changes while granted do not reach blink_flag.
        req_mode  = 8'b00_00_00_01;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        req_mode  = 8'b00_00_00_10;
        repeat (3) @(negedge clk);
        chk("latch_blink", 32'(blink_flag), 32'h1);
        repeat (8) @(negedge clk);

        // Mixed request stream, checked by the model every cycle.
        req_mode = 8'b11_10_01_11;
        for (int k = 0; k < 48; k++) begin
            req_valid = tbl_valid[k % 8];
            if (k == 30) req_mode = 8'b01_11_11_10;
            @(negedge clk);
        end
        req_valid = 4'b0000;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
